// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions: pointer width, Gray encoding, reset values.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int PTR_WIDTH      = DEF_ADDR_WIDTH + 1;
    localparam int GRAY_MAX_W     = 32;

    localparam logic RST_EMPTY     = 1'b1;
    localparam logic RST_UNDERFLOW = 1'b0;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter.
// Latency: combinational. No backpressure.
// Each binary bit is the XOR of all Gray bits at and above it.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: STAGES clocks. No backpressure; samples every edge.
// Reset: asynchronous active-low, all stages cleared.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Async-FIFO read-side pointer/empty/level controller; optional sticky underflow_o via RD_UNDERFLOW_EN.
// Latency: read updates pointer/flags on the accepting edge; write pointer visible after SYNC_STAGES edges.
// Backpressure: rd_ack_o = rd_en_i & ~empty_o; reads while empty are dropped without state change.
module rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH:0]   wptr_gray_i,
    output logic                  rd_ack_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic [ADDR_WIDTH:0]   rptr_gray_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   level_o
`ifdef RD_UNDERFLOW_EN
    ,
    output logic                  underflow_o
`endif
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wgray_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          acc;

    // Only the Gray-coded write pointer crosses into this domain.
    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (wptr_gray_i),
        .q_o     (wgray_s)
    );

    gray2bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray_i (wgray_s),
        .bin_o  (wbin_s)
    );

    assign acc        = rd_en_i & ~empty_o;
    assign rd_ack_o   = acc;
    assign rbin_next  = rbin + PW'(acc);
    assign rgray_next = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));
    assign raddr_o    = rbin[ADDR_WIDTH-1:0];

    // Flags use the post-read pointer so the last entry's read closes the FIFO on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rbin        <= '0;
            rptr_gray_o <= '0;
            empty_o     <= RST_EMPTY;
            level_o     <= '0;
        end else begin
            rbin        <= rbin_next;
            rptr_gray_o <= rgray_next;
            empty_o     <= (rgray_next == wgray_s);
            level_o     <= wbin_s - rbin_next;
        end
    end

`ifdef RD_UNDERFLOW_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            underflow_o <= RST_UNDERFLOW;
        end else if (rd_en_i & empty_o) begin
            underflow_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Bench for rd_ptr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2): directed scenarios plus random traffic
// against a count-based reference model.
module tb_rd_ptr_ctrl;

    localparam int AW  = 4;
    localparam int SS  = 2;
    localparam int MOD = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] wgray = '0;
    logic       rd_ack;
    logic [3:0] raddr;
    logic [4:0] rgray;
    logic       empty;
    logic [4:0] level;
`ifdef RD_UNDERFLOW_EN
    logic       uf;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: counts of entries written / read, modulo 2^(AW+1).
    int m_w;
    int m_rc;
    int m_level;
    bit m_empty;
    bit m_uf;
    int wq[$];

    rd_ptr_ctrl #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .rd_en_i     (rd_en),
        .wptr_gray_i (wgray),
        .rd_ack_o    (rd_ack),
        .raddr_o     (raddr),
        .rptr_gray_o (rgray),
        .empty_o     (empty),
        .level_o     (level)
`ifdef RD_UNDERFLOW_EN
        ,
        .underflow_o (uf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray_of(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w     = 0;
        m_rc    = 0;
        m_level = 0;
        m_empty = 1'b1;
        m_uf    = 1'b0;
        wq.delete();
        for (int i = 0; i < SS; i++) wq.push_back(0);
        wgray = '0;
    endtask

    task automatic drive(input bit rd, input int w);
        rd_en = rd;
        m_w   = w % MOD;
        wgray = gray_of(m_w);
    endtask

    task automatic compare_all();
        check("raddr", int'(raddr), m_rc % 16);
        check("rptr_gray", int'(rgray), int'(gray_of(m_rc)));
        check("empty", int'(empty), int'(m_empty));
        check("level", int'(level), m_level);
`ifdef RD_UNDERFLOW_EN
        check("underflow", int'(uf), int'(m_uf));
`endif
    endtask

    // Called at a negedge after inputs are driven; advances one clock and compares.
    task automatic step();
        int vis;
        int acc;
        #1;
        check("rd_ack", int'(rd_ack), int'(rd_en & ~m_empty));
        @(posedge clk);
        vis = wq[SS-1];
        acc = (rd_en && !m_empty) ? 1 : 0;
        if (rd_en && m_empty) m_uf = 1'b1;
        m_rc    = (m_rc + acc) % MOD;
        m_empty = (m_rc == vis);
        m_level = (vis - m_rc + MOD) % MOD;
        wq.push_front(m_w);
        void'(wq.pop_back());
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_phase(input int n);
        int nw;
        bit rd;
        for (int i = 0; i < n; i++) begin
            rd = ($urandom_range(0, 99) < 45);
            nw = m_w;
            if ($urandom_range(0, 99) < 55 && ((m_w + 1 - m_rc + MOD) % MOD) <= 16) nw = m_w + 1;
            drive(rd, nw);
            step();
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_empty", int'(empty), 1);
        check("rst_level", int'(level), 0);
        check("rst_raddr", int'(raddr), 0);
        check("rst_rgray", int'(rgray), 0);
        check("rst_rd_ack", int'(rd_ack), 0);
        compare_all();
        rst_n = 1'b1;

        // First write becomes visible exactly two edges after it is sampled.
        drive(0, 1);
        step();
        check("release_edge_n", int'(empty), 1);
        step();
        check("release_edge_n1", int'(empty), 1);
        step();
        check("release_edge_n2_empty", int'(empty), 0);
        check("release_edge_n2_level", int'(level), 1);

        drive(1, 1);
        #1;
        check("single_rd_ack", int'(rd_ack), 1);
        step();
        check("single_raddr", int'(raddr), 1);
        check("single_rgray", int'(rgray), 5'b00001);
        check("single_empty", int'(empty), 1);
        check("single_level", int'(level), 0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 1);
            step();
            check("rd_on_empty_ack", int'(rd_ack), 0);
            check("rd_on_empty_raddr", int'(raddr), 1);
        end
`ifdef RD_UNDERFLOW_EN
        check("underflow_set", int'(uf), 1);
`endif

        // Fill to 16 from a fresh pointer.
        do_reset();
        for (int w = 1; w <= 16; w++) begin
            drive(0, w);
            step();
        end
        repeat (3) step();
        check("full_level", int'(level), 5'b10000);
        check("full_empty", int'(empty), 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, 16);
            step();
        end
        check("drain_raddr", int'(raddr), 0);
        check("drain_rgray", int'(rgray), 5'b11000);
        check("drain_empty", int'(empty), 1);

        // Write pointer runs 17..31 then wraps to 0; reads follow it round.
        for (int w = 17; w <= 32; w++) begin
            drive(0, w);
            step();
        end
        repeat (3) step();
        check("wrap_level", int'(level), 16);
        for (int i = 0; i < 16; i++) begin
            drive(1, 32);
            step();
        end
        check("wrap_rgray", int'(rgray), 5'b00000);
        check("wrap_empty", int'(empty), 1);
        check("wrap_level0", int'(level), 0);

        random_phase(400);

        // Asynchronous reset between edges with five entries pending.
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            drive(0, w);
            step();
        end
        repeat (3) step();
        check("pre_reset_level", int'(level), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_empty", int'(empty), 1);
        check("async_rst_level", int'(level), 0);
        check("async_rst_raddr", int'(raddr), 0);
        check("async_rst_rgray", int'(rgray), 0);
        model_reset();
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0);
        step();
        check("post_reset_empty", int'(empty), 1);
        random_phase(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rd_ptr_ctrl.md
Name: rd_ptr_ctrl

Overview:
Read-domain pointer and empty-flag controller for the asynchronous FIFO. It takes the write pointer as raw Gray code from the write clock domain and synchronises it. The synchronised value goes through a gray2bin converter to produce a binary write pointer. From that, the block keeps the read pointer, RAM read address, outgoing Gray read pointer, registered empty flag and read-side occupancy count.

Parameters:
ADDR_WIDTH, 4, RAM address width; pointers are ADDR_WIDTH+1 bits (extra wrap bit)
SYNC_STAGES, 2, flop stages in the write-pointer synchroniser; legal values 2..4

Ports:
clk_i  input  1  read-domain clock
rst_n_i  input  1  reset, asynchronous assert, active-low
rd_en_i  input  1  read request from consumer
wptr_gray_i  input  ADDR_WIDTH+1  write pointer, Gray code, write-clock domain (asynchronous to clk_i)
rd_ack_o  output  1  read accepted this cycle; combinational: rd_en_i & ~empty_o
raddr_o  output  ADDR_WIDTH  RAM read address, equals rbin[ADDR_WIDTH-1:0]
rptr_gray_o  output  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchroniser
empty_o  output  1  registered empty flag
level_o  output  ADDR_WIDTH+1  registered occupancy as seen from the read side, 0..2^ADDR_WIDTH

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- Reset values: all synchroniser stages 0; rbin 0; rptr_gray_o 0; empty_o 1; level_o 0; raddr_o 0.
- Synchroniser: SYNC_STAGES-flop chain on wptr_gray_i; the last stage is wgray_s. wbin_s = gray2bin(wgray_s).
- Accept rule: acc = rd_en_i & ~empty_o. When acc=0 (including rd_en_i while empty), the pointer holds and no state changes.
- Pointer update: rbin_next = rbin + acc, modulo 2^(ADDR_WIDTH+1).
- Gray update: rgray_next = rbin_next ^ (rbin_next >> 1). Both rbin and rptr_gray_o register their next values every edge.
- Empty: empty_o <= (rgray_next == wgray_s). Compare the full ADDR_WIDTH+1 bits, wrap bit included.
- Level: level_o <= (wbin_s - rbin_next) modulo 2^(ADDR_WIDTH+1). Equals 2^ADDR_WIDTH when full.
- Latency, write to read side: a change on wptr_gray_i sampled at edge n appears in empty_o/level_o after edge n+SYNC_STAGES.
- Latency, read to flags: an accepted read at edge n updates raddr_o, rptr_gray_o, empty_o and level_o at that same edge n.
- Last-entry read: reading the final entry sets empty_o=1 on the same edge, so no back-to-back over-read is possible.
- Simultaneous read and write-pointer change: each is handled independently; empty uses the post-read pointer against the current wgray_s.
- Wrap-around: rbin rolls from 2^(ADDR_WIDTH+1)-1 to 0; raddr_o wraps every 2^ADDR_WIDTH reads.
- Empty versus full: pointers equal including the wrap bit means empty; differing only in the wrap bit means level 2^ADDR_WIDTH.
- Reset mid-operation: asserting rst_n_i forces all registers to reset values immediately, independent of clk_i. Deassertion is expected synchronised externally.
- Multi-bit crossing: only the Gray-coded pointer crosses domains; no other multi-bit signal may cross.

Optional Feature:
RD_UNDERFLOW_EN
- Defined: adds output underflow_o (1 bit, reset 0). It is sticky: set on any edge where rd_en_i & empty_o, and cleared only by reset.
- Undefined: no port, no logic; attempted reads on empty are silently ignored as described above.

Decomposition:
- Shared package fifo_pkg: PTR_WIDTH = ADDR_WIDTH+1 derivation, bin2gray function, reset-value constants. These are shared with the write-side controller.
- Sub-module ptr_sync: parameterised WIDTH x SYNC_STAGES flop chain with async active-low reset. It is reused by the write side for rptr_gray_o.
- The existing gray2bin module is instantiated directly for wbin_s.

Test Plan:
All scenarios use ADDR_WIDTH=4, SYNC_STAGES=2.
- Reset: assert rst_n_i=0 -> empty_o=1, level_o=0, raddr_o=0, rptr_gray_o=00000, rd_ack_o=0.
- Empty release: wptr_gray_i 00000->00001 at edge n -> empty_o=0 and level_o=1 after edge n+2, not earlier. Then rd_en_i for 1 cycle -> rd_ack_o=1, raddr_o=1, rptr_gray_o=00001, empty_o=1, level_o=0 on that edge.
- Read on empty: hold rd_en_i=1 for 5 cycles with empty_o=1 -> rd_ack_o=0 throughout, raddr_o unchanged; underflow_o=1 and stays 1 when RD_UNDERFLOW_EN is defined.
- Full level: rbin=0, wptr_gray_i=11000 (bin 16) -> level_o=10000, empty_o=0. Read 16 times -> rbin=10000, raddr_o=0, rptr_gray_o=11000, empty_o=1.
- Wrap-around: continue writes to bin 31 then 0 (gray 10000 then 00000) and read all -> rbin rolls 11111->00000, rptr_gray_o 10000->00000, empty_o=1, level_o=0.
- Async reset mid-stream: pull rst_n_i low between clock edges while level_o=5 -> all outputs reach reset values before the next clk_i edge. Release -> normal operation with empty_o=1.
